sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one 256x16 SRAM pair (two gf180mcu sram256x8 macros, LSB/MSB) between the
//  processor port and the host/IO-interface port. Sits between processor/io_interface
//  and the macros; one instance serves data memory, one serves instruction memory.
//  Host owns memory while processor idle/halted; processor has priority when running;
//  starvation counter guarantees the host a slot.
// PARAMETERS
//  AW        8   address width (256 words)
//  DW        16  data width (two 8-bit macros)
//  MAX_WAIT  15  max consecutive cycles a pending host request loses before a forced slot
// PORTS
//  clk          in   1   system clock; macros clocked by the same clk
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   run request from io_interface (level)
//  hlt          in   1   processor halted (level)
//  up_req       in   1   processor access request this cycle
//  up_we        in   1   processor write (1) / read (0)
//  up_addr      in   AW  processor address
//  up_wdata     in   DW  processor write data
//  up_rdata     out  DW  read data to processor (= mem_q)
//  up_stall     out  1   processor access not performed this cycle; processor holds request
//  host_valid   in   1   host request pending
//  host_we      in   1   host write (1) / read (0)
//  host_addr    in   AW  host address
//  host_wdata   in   DW  host write data
//  host_ready   out  1   host request accepted this cycle (valid & ready = transfer)
//  host_rvalid  out  1   host read data valid (one cycle after accepted read)
//  host_rdata   out  DW  host read data (= mem_q)
//  mem_cen_n    out  1   macro chip enable, active-low
//  mem_gwen_n   out  1   macro global write enable, active-low
//  mem_wen_n    out  DW  macro bit write enables, active-low (all = mem_gwen_n)
//  mem_addr     out  AW  macro address
//  mem_d        out  DW  macro write data
//  mem_q        in   DW  macro read data
// BEHAVIOUR
//  States: HOST_OWN (reset state), SHARED, HALTED. Registered; transitions on clk rise.
//   HOST_OWN: start=1 -> SHARED. SHARED: start=0 -> HOST_OWN; else hlt=1 -> HALTED.
//   HALTED: start=0 -> HOST_OWN (hlt ignored). start=0 always wins over hlt.
//  Grant (combinational from state, requests, wait_cnt):
//   HOST_OWN/HALTED: host granted iff host_valid; up_stall=1.
//   SHARED: host granted iff host_valid & (~up_req | wait_cnt==MAX_WAIT);
//   otherwise processor granted iff up_req. up_stall = up_req & host granted.
//  host_ready = host grant. mem_cen_n = ~(any grant). mem_gwen_n = ~(granted we);
//   mem_addr/mem_d muxed from granted port; with no grant drive processor fields.
//  wait_cnt: clog2(MAX_WAIT+1) bits; +1 each cycle host_valid & ~host_ready, saturating
//   at MAX_WAIT; cleared on host grant or host_valid=0; forced 0 outside SHARED.
//  Read latency 1: host_rvalid registered = host grant & ~host_we of previous cycle;
//   host_rdata/up_rdata = mem_q passthrough (valid only in the cycle after a read grant).
//  Write-then-read same address on consecutive cycles returns new data (macro behaviour).
//  Reset (reset=0, async): state=HOST_OWN, wait_cnt=0, host_rvalid=0; while asserted
//   force mem_cen_n=1, mem_gwen_n=1, mem_wen_n=all 1, host_ready=0, up_stall=1.
//   Reset mid-access aborts it; no rvalid issued for an aborted read.
//  State change mid-stream: pending rvalid still issued the cycle after its grant.
// STRUCTURE
//  Package mem_arb_pkg: state enum {HOST_OWN, SHARED, HALTED}, owner encoding
//   {OWN_NONE, OWN_UP, OWN_HOST}, default AW/DW constants.
//  Sub-module arb_wait_counter: saturating counter (inc, clr, sat flag); top holds FSM,
//   grant mux and rvalid register.
// TESTING
//  T1 reset=0 with host_valid=1 -> mem_cen_n=1, host_ready=0, up_stall=1; release -> HOST_OWN.
//  T2 HOST_OWN: write 0xA5C3 @0x10, read @0x10 -> host_rvalid next cycle, host_rdata=0xA5C3.
//  T3 SHARED, up_req=1 every cycle, host_valid=1 held -> host_ready on 16th cycle
//   (wait_cnt 15), up_stall=1 exactly that cycle, counter back to 0.
//  T4 SHARED, up_req=1 with host_valid=1 and up_req toggled off -> host granted in up_req=0 cycle,
//   no stall; processor write 0x1234 @0xFF then read -> up_rdata=0x1234.
//  T5 hlt=1 -> HALTED, host gets every cycle; start=0 and hlt=1 same cycle from SHARED -> HOST_OWN.
//  T6 reset pulse in cycle after host read grant -> host_rvalid stays 0, outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the SRAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_AW       = 8;
  localparam int unsigned ARB_DW       = 16;
  localparam int unsigned ARB_MAX_WAIT = 15;

  // Who owns the memory: host alone, both ports shared, or processor halted.
  typedef enum logic [1:0] {
    HOST_OWN = 2'd0,
    SHARED   = 2'd1,
    HALTED   = 2'd2
  } arb_state_e;

  // Which port drives the macros this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_UP   = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating counter of consecutive cycles a pending host request has lost.
module arb_wait_counter #(
  parameter int unsigned MAX = 15,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q;

  // Clear has priority; increment stops at MAX so the forced slot stays armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates one 256x16 SRAM pair between the processor and host ports.
// Handshake: a host transfer happens on a rising edge where host_valid and
// host_ready are both 1; host_rvalid follows an accepted read by one cycle.
// The processor holds its request while up_stall is 1.
module sram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = ARB_AW,
  parameter int unsigned DW       = ARB_DW,
  parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          hlt,
  input  logic          up_req,
  input  logic          up_we,
  input  logic [AW-1:0] up_addr,
  input  logic [DW-1:0] up_wdata,
  output logic [DW-1:0] up_rdata,
  output logic          up_stall,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_cen_n,
  output logic          mem_gwen_n,
  output logic [DW-1:0] mem_wen_n,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output arb_state_e    dbg_state
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  arb_state_e   state_q;
  owner_e       owner;
  logic         host_gnt;
  logic         up_gnt;
  logic         rvalid_q;
  logic         in_shared;
  logic         wait_inc;
  logic         wait_clr;
  logic         wait_sat;
  logic [CW-1:0] wait_cnt;

  assign in_shared = (state_q == SHARED);

  // Ownership FSM: start=0 always returns ownership to the host, even over hlt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOST_OWN;
    end else begin
      case (state_q)
        HOST_OWN: if (start) state_q <= SHARED;
        SHARED: begin
          if (!start)   state_q <= HOST_OWN;
          else if (hlt) state_q <= HALTED;
        end
        HALTED:   if (!start) state_q <= HOST_OWN;
        default:  state_q <= HOST_OWN;
      endcase
    end
  end

  // Grant selection; in SHARED the processor wins unless the host has starved.
  always_comb begin
    host_gnt = 1'b0;
    up_gnt   = 1'b0;
    if (in_shared) begin
      if (host_valid && (!up_req || wait_sat)) host_gnt = 1'b1;
      else if (up_req)                          up_gnt   = 1'b1;
    end else begin
      host_gnt = host_valid;
    end
    if (!reset) begin
      host_gnt = 1'b0;
      up_gnt   = 1'b0;
    end
    if (host_gnt)    owner = OWN_HOST;
    else if (up_gnt) owner = OWN_UP;
    else             owner = OWN_NONE;
  end

  // Starvation counter only runs while the processor competes for the macros.
  assign wait_inc = host_valid & ~host_gnt & in_shared;
  assign wait_clr = host_gnt | ~host_valid | ~in_shared;

  arb_wait_counter #(
    .MAX (MAX_WAIT),
    .W   (CW)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (wait_inc),
    .clr_i (wait_clr),
    .cnt_o (wait_cnt),
    .sat_o (wait_sat)
  );

  // Read-data valid for the host, one cycle after an accepted host read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= host_gnt & ~host_we;
    end
  end

  assign host_ready  = host_gnt;
  assign up_stall    = !reset ? 1'b1 : (in_shared ? (up_req & host_gnt) : 1'b1);
  assign host_rvalid = rvalid_q;
  assign host_rdata  = mem_q;
  assign up_rdata    = mem_q;

  assign mem_cen_n  = ~(host_gnt | up_gnt);
  assign mem_gwen_n = (owner == OWN_HOST) ? ~host_we :
                      (owner == OWN_UP)   ? ~up_we   : 1'b1;
  assign mem_wen_n  = {DW{mem_gwen_n}};
  assign mem_addr   = (owner == OWN_HOST) ? host_addr  : up_addr;
  assign mem_d      = (owner == OWN_HOST) ? host_wdata : up_wdata;
  assign dbg_state  = state_q;

  logic unused_ok;
  assign unused_ok = ^wait_cnt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with a behavioural SRAM model and read scoreboard.
module tb_sram_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        hlt;
  logic        up_req;
  logic        up_we;
  logic [7:0]  up_addr;
  logic [15:0] up_wdata;
  logic [15:0] up_rdata;
  logic        up_stall;
  logic        host_valid;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ready;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        mem_cen_n;
  logic        mem_gwen_n;
  logic [15:0] mem_wen_n;
  logic [7:0]  mem_addr;
  logic [15:0] mem_d;
  logic [15:0] mem_q;
  arb_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sram [256];

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .hlt         (hlt),
    .up_req      (up_req),
    .up_we       (up_we),
    .up_addr     (up_addr),
    .up_wdata    (up_wdata),
    .up_rdata    (up_rdata),
    .up_stall    (up_stall),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_cen_n   (mem_cen_n),
    .mem_gwen_n  (mem_gwen_n),
    .mem_wen_n   (mem_wen_n),
    .mem_addr    (mem_addr),
    .mem_d       (mem_d),
    .mem_q       (mem_q),
    .dbg_state   (dbg_state)
  );

  // SRAM macro pair model: synchronous, write-then-read returns the new word.
  initial mem_q = 16'h0000;
  always @(posedge clk) begin
    if (!mem_cen_n) begin
      if (!mem_gwen_n) sram[mem_addr] <= mem_d;
      else             mem_q <= sram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Host driver: call just after a rising edge; returns just after the transfer edge.
  task automatic host_xfer(input logic we, input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] exp, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    host_valid = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host_ready === 1'b1) begin
        ok = 1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL host_timeout: addr 0x%0h not accepted within 40 cycles", a);
    end else if (!we) begin
      exp_q.push_back(exp);
    end
    step();
    host_valid = 1'b0;
  endtask

  // Monitor: every host_rvalid must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (host_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata 0x%0h with no read outstanding", host_rdata);
      end else begin
        check("host_rdata", {16'h0, host_rdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int w;
    reset = 1'b0; start = 1'b0; hlt = 1'b0;
    up_req = 1'b0; up_we = 1'b0; up_addr = 8'h00; up_wdata = 16'h0000;
    host_valid = 1'b0; host_we = 1'b1; host_addr = 8'h00; host_wdata = 16'h0000;

    // T1: reset dominates a pending host request
    host_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_cen_in_reset", mem_cen_n, 1);
    check("t1_gwen_in_reset", mem_gwen_n, 1);
    check("t1_wen_in_reset", mem_wen_n, 16'hFFFF);
    check("t1_ready_in_reset", host_ready, 0);
    check("t1_stall_in_reset", up_stall, 1);
    check("t1_rvalid_in_reset", host_rvalid, 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("t1_state_after_reset", dbg_state, HOST_OWN);
    check("t1_ready_after_reset", host_ready, 1);
    step();
    host_valid = 1'b0;

    // T2: host write then read on consecutive cycles
    host_xfer(1'b1, 8'h10, 16'hA5C3, 16'h0, w);
    check("t2_write_wait", w, 0);
    host_xfer(1'b0, 8'h10, 16'h0, 16'hA5C3, w);
    check("t2_read_wait", w, 0);
    @(negedge clk);
    check("t2_rvalid_latency", host_rvalid, 1);
    step();

    // T3: processor hogs the memory; host forced in on its 16th cycle
    start = 1'b1;
    step();
    up_req = 1'b1; up_we = 1'b0; up_addr = 8'h10;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 16'hBEEF;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) check("t3_state_shared", dbg_state, SHARED);
      check($sformatf("t3_ready_c%0d", c), host_ready, (c == 16) ? 1 : 0);
      check($sformatf("t3_stall_c%0d", c), up_stall, (c == 16) ? 1 : 0);
      step();
    end
    host_addr = 8'h21; host_wdata = 16'h0BAD;
    @(negedge clk);
    check("t3_cnt_cleared_ready", host_ready, 0);
    check("t3_cnt_cleared_stall", up_stall, 0);
    step();
    host_valid = 1'b0; up_req = 1'b0;

    // T4: host takes the slot the processor leaves; processor write/read
    up_req = 1'b1; up_we = 1'b0; up_addr = 8'h10;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 16'h5A5A;
    @(negedge clk);
    check("t4_ready_up_busy", host_ready, 0);
    check("t4_stall_up_busy", up_stall, 0);
    step();
    up_req = 1'b0;
    @(negedge clk);
    check("t4_ready_up_idle", host_ready, 1);
    check("t4_stall_up_idle", up_stall, 0);
    step();
    host_valid = 1'b0;
    up_req = 1'b1; up_we = 1'b1; up_addr = 8'hFF; up_wdata = 16'h1234;
    @(negedge clk);
    check("t4_up_wr_stall", up_stall, 0);
    check("t4_up_wr_gwen", mem_gwen_n, 0);
    check("t4_up_wr_addr", mem_addr, 8'hFF);
    check("t4_up_wr_data", mem_d, 16'h1234);
    step();
    up_we = 1'b0;
    @(negedge clk);
    check("t4_up_rd_cen", mem_cen_n, 0);
    check("t4_up_rd_gwen", mem_gwen_n, 1);
    step();
    up_req = 1'b0;
    @(negedge clk);
    check("t4_up_rdata", up_rdata, 16'h1234);
    check("t4_idle_cen", mem_cen_n, 1);

    // T5: halted processor; host gets every cycle
    hlt = 1'b1; up_req = 1'b1;
    step();
    @(negedge clk);
    check("t5_state_halted", dbg_state, HALTED);
    check("t5_stall_halted", up_stall, 1);
    check("t5_cen_halted_idle", mem_cen_n, 1);
    step();
    host_xfer(1'b0, 8'h30, 16'h0, 16'h5A5A, w);
    check("t5_wait_rd0", w, 0);
    host_xfer(1'b0, 8'hFF, 16'h0, 16'h1234, w);
    check("t5_wait_rd1", w, 0);
    host_xfer(1'b0, 8'h20, 16'h0, 16'hBEEF, w);
    check("t5_wait_rd2", w, 0);
    up_req = 1'b0;
    start = 1'b0;
    step();
    @(negedge clk);
    check("t5_halted_to_host", dbg_state, HOST_OWN);
    hlt = 1'b0; start = 1'b1;
    step();
    @(negedge clk);
    check("t5_back_to_shared", dbg_state, SHARED);
    start = 1'b0; hlt = 1'b1;
    step();
    @(negedge clk);
    check("t5_start0_beats_hlt", dbg_state, HOST_OWN);
    hlt = 1'b0;

    // T6: reset right after a host read grant aborts the read
    step();
    host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    @(negedge clk);
    check("t6_ready_before_abort", host_ready, 1);
    step();
    reset = 1'b0;
    host_valid = 1'b0;
    @(negedge clk);
    check("t6_rvalid_aborted", host_rvalid, 0);
    check("t6_cen_reset", mem_cen_n, 1);
    check("t6_gwen_reset", mem_gwen_n, 1);
    check("t6_wen_reset", mem_wen_n, 16'hFFFF);
    check("t6_ready_reset", host_ready, 0);
    check("t6_stall_reset", up_stall, 1);
    check("t6_state_reset", dbg_state, HOST_OWN);
    step();
    reset = 1'b1;
    step();
    host_xfer(1'b0, 8'h10, 16'h0, 16'hA5C3, w);
    check("t6_wait_after_reset", w, 0);
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reads_outstanding: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
